ysyx_24110015_stage_ctrl: RTL and testbench

YSYX_24110015_STAGE_CTRL -- requirements
Module: ysyx_24110015_stage_ctrl

---
 rtl/ysyx_24110015_ctrl_pkg.sv | 41 ++++
 rtl/ysyx_24110015_timeout_cnt.sv | 54 +++++
 rtl/ysyx_24110015_stage_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ysyx_24110015_stage_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_ctrl_pkg
//
// Shared definitions for the stage controller:
//   - ctrl_state_e : 4-bit encoding of the controller states, also exported on
//                    the state_o debug port, so the values are fixed.
//   - CAUSE_*      : encodings driven on fault_cause_o.
//   - isWaitState  : states in which the handshake timeout timer runs.
//   - isCounting   : states in which the cycle counter advances.
// ---------------------------------------------------------------------------
package ysyx_24110015_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_WAIT_I = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WAIT_M = 4'd5,
        ST_WB     = 4'd6,
        ST_HALT   = 4'd7,
        ST_FAULT  = 4'd8
    } ctrl_state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_IFETCH = 2'd1;
    localparam logic [1:0] CAUSE_LSU    = 2'd2;

    // The timer watches the whole request/response window of one memory,
    // so both the request state and the response state count against it.
    function automatic logic isWaitState(input ctrl_state_e s);
        return (s == ST_FETCH) || (s == ST_WAIT_I) ||
               (s == ST_MEM)   || (s == ST_WAIT_M);
    endfunction

    // The core is considered busy everywhere except while parked.
    function automatic logic isCounting(input ctrl_state_e s);
        return !((s == ST_IDLE) || (s == ST_HALT) || (s == ST_FAULT));
    endfunction

endpackage

// File: rtl/ysyx_24110015_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_timeout_cnt
//
// Handshake watchdog. Counts cycles spent waiting for a memory handshake and
// flags when the next waiting cycle would reach TIMEOUT.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-low reset (clears the count)
//   clear_i   in   restart the window (has priority over enable_i)
//   enable_i  in   one more cycle spent waiting
//   expire_o  out  this waiting cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module ysyx_24110015_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TO_W-1:0] LastCount = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] MaxCount  = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // The count saturates at TIMEOUT so that a handshake winning the race
    // against expiry does not let the counter wrap back into a long window
    // while still waiting for the response half of the transaction.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != MaxCount)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q >= LastCount);

endmodule

// File: rtl/ysyx_24110015_stage_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_stage_ctrl
//
// Multi-cycle control FSM for a simple in-order core:
//   IDLE -> FETCH -> WAIT_I -> EXEC -> [MEM -> WAIT_M ->] WB -> FETCH ...
// with EXEC branching to HALT on ebreak, and FETCH/WAIT_I/MEM/WAIT_M falling
// into FAULT when a memory handshake takes too long. HALT and FAULT are only
// left through reset.
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-low reset
//   start_i                 leave IDLE
//   ifu_req_valid_o/ready_i instruction fetch request handshake
//   ifu_resp_valid_i        fetched instruction available
//   inst_latch_o            capture strobe for the IFU (WAIT_I only)
//   is_load_i, is_store_i,
//   rf_write_i, is_ebreak_i decode flags, sampled in EXEC
//   lsu_req_valid_o/wen_o/
//   lsu_req_ready_i         data memory request handshake
//   lsu_resp_valid_i        data memory response
//   rf_wen_o, pc_wen_o      commit pulses, WB only
//   halted_o, fault_o       registered terminal-state flags
//   fault_cause_o           0 none, 1 fetch timeout, 2 lsu timeout
//   state_o                 current state encoding
//   cycle_cnt_o, instret_o  performance counters, wrap modulo 2^CNT_W
// ---------------------------------------------------------------------------
module ysyx_24110015_stage_ctrl
    import ysyx_24110015_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             ifu_req_valid_o,
    input  logic             ifu_req_ready_i,
    input  logic             ifu_resp_valid_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic             rf_write_i,
    input  logic             is_ebreak_i,
    output logic             lsu_req_valid_o,
    output logic             lsu_req_wen_o,
    input  logic             lsu_req_ready_i,
    input  logic             lsu_resp_valid_i,
    output logic             inst_latch_o,
    output logic             rf_wen_o,
    output logic             pc_wen_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [1:0]       fault_cause_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_o
);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic             isStore_q;
    logic             rfWrite_q;
    logic [CNT_W-1:0] cycleCnt_q;
    logic [CNT_W-1:0] instret_q;
    logic             halted_q;
    logic             fault_q;
    logic [1:0]       faultCause_q;
    logic [1:0]       faultCause_d;
    logic             instretInc;
    logic             timerClear;
    logic             timerEnable;
    logic             timerExpire;

    // The timer restarts whenever a new wait window opens (entering FETCH or
    // MEM from another state) and advances only while actually waiting.
    assign timerClear  = (state_d != state_q) &&
                         ((state_d == ST_FETCH) || (state_d == ST_MEM));
    assign timerEnable = isWaitState(state_q);

    ysyx_24110015_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timerClear),
        .enable_i (timerEnable),
        .expire_o (timerExpire)
    );

    // Next-state and output decode. Every handshake is tested before the
    // timeout so that a handshake arriving on the expiry cycle still wins.
    // All handshake/pulse outputs are gated by rst_i so nothing is issued
    // while reset is held, even before the first reset edge lands.
    always_comb begin
        state_d         = state_q;
        faultCause_d    = faultCause_q;
        instretInc      = 1'b0;
        ifu_req_valid_o = 1'b0;
        inst_latch_o    = 1'b0;
        lsu_req_valid_o = 1'b0;
        lsu_req_wen_o   = 1'b0;
        rf_wen_o        = 1'b0;
        pc_wen_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ifu_req_valid_o = rst_i;
                if (ifu_req_ready_i) begin
                    state_d = ST_WAIT_I;
                end else if (timerExpire) begin
                    state_d      = ST_FAULT;
                    faultCause_d = CAUSE_IFETCH;
                end
            end
            ST_WAIT_I: begin
                inst_latch_o = rst_i && ifu_resp_valid_i;
                if (ifu_resp_valid_i) begin
                    state_d = ST_EXEC;
                end else if (timerExpire) begin
                    state_d      = ST_FAULT;
                    faultCause_d = CAUSE_IFETCH;
                end
            end
            ST_EXEC: begin
                // ebreak retires without a PC update and outranks memory ops.
                if (is_ebreak_i) begin
                    state_d    = ST_HALT;
                    instretInc = 1'b1;
                end else if (is_load_i || is_store_i) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                lsu_req_valid_o = rst_i;
                lsu_req_wen_o   = rst_i && isStore_q;
                if (lsu_req_ready_i) begin
                    state_d = ST_WAIT_M;
                end else if (timerExpire) begin
                    state_d      = ST_FAULT;
                    faultCause_d = CAUSE_LSU;
                end
            end
            ST_WAIT_M: begin
                if (lsu_resp_valid_i) begin
                    state_d = ST_WB;
                end else if (timerExpire) begin
                    state_d      = ST_FAULT;
                    faultCause_d = CAUSE_LSU;
                end
            end
            ST_WB: begin
                // A store never writes the register file, whatever rf_write said.
                pc_wen_o   = rst_i;
                rf_wen_o   = rst_i && rfWrite_q && !isStore_q;
                instretInc = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State, latched decode flags, counters and terminal flags.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            isStore_q    <= 1'b0;
            rfWrite_q    <= 1'b0;
            cycleCnt_q   <= '0;
            instret_q    <= '0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            faultCause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            faultCause_q <= faultCause_d;
            if (state_q == ST_EXEC) begin
                isStore_q <= is_store_i;
                rfWrite_q <= rf_write_i;
            end
            if (isCounting(state_q)) begin
                cycleCnt_q <= cycleCnt_q + 1'b1;
            end
            if (instretInc) begin
                instret_q <= instret_q + 1'b1;
            end
            if (state_d == ST_HALT) begin
                halted_q <= 1'b1;
            end
            if (state_d == ST_FAULT) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = faultCause_q;
    assign state_o       = state_q;
    assign cycle_cnt_o   = cycleCnt_q;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_ysyx_24110015_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_stage_ctrl
//
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model of the controller kept in this file.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_stage_ctrl;
    import ysyx_24110015_ctrl_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             rst;
    logic             start;
    logic             ifuReqValid;
    logic             ifuReqReady;
    logic             ifuRespValid;
    logic             isLoad;
    logic             isStore;
    logic             rfWrite;
    logic             isEbreak;
    logic             lsuReqValid;
    logic             lsuReqWen;
    logic             lsuReqReady;
    logic             lsuRespValid;
    logic             instLatch;
    logic             rfWen;
    logic             pcWen;
    logic             halted;
    logic             fault;
    logic [1:0]       faultCause;
    logic [3:0]       state;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instret;

    ysyx_24110015_stage_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .ifu_req_valid_o  (ifuReqValid),
        .ifu_req_ready_i  (ifuReqReady),
        .ifu_resp_valid_i (ifuRespValid),
        .is_load_i        (isLoad),
        .is_store_i       (isStore),
        .rf_write_i       (rfWrite),
        .is_ebreak_i      (isEbreak),
        .lsu_req_valid_o  (lsuReqValid),
        .lsu_req_wen_o    (lsuReqWen),
        .lsu_req_ready_i  (lsuReqReady),
        .lsu_resp_valid_i (lsuRespValid),
        .inst_latch_o     (instLatch),
        .rf_wen_o         (rfWen),
        .pc_wen_o         (pcWen),
        .halted_o         (halted),
        .fault_o          (fault),
        .fault_cause_o    (faultCause),
        .state_o          (state),
        .cycle_cnt_o      (cycleCnt),
        .instret_o        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: where the controller is, how long the current memory
    // window has lasted, what EXEC captured, and the architectural counters.
    ctrl_state_e mState     = ST_IDLE;
    int          mWaited    = 0;
    bit          mStore     = 0;
    bit          mRfw       = 0;
    bit          mHalted    = 0;
    bit          mFault     = 0;
    int          mCause     = 0;
    int          mCycle     = 0;
    int          mInstret   = 0;
    bit          modelValid = 0;

    int pcSeen;
    int rfSeen;
    int wenSeen;
    int lsuReqSeen;

    // Single point of comparison: count it, report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output with what the model says for this cycle.
    task automatic checkAgainstModel();
        bit live;
        live = rst;
        checkOutput("state",         32'(state),        32'(mState));
        checkOutput("ifu_req_valid", 32'(ifuReqValid),  32'(live && mState == ST_FETCH));
        checkOutput("inst_latch",    32'(instLatch),    32'(live && mState == ST_WAIT_I && ifuRespValid));
        checkOutput("lsu_req_valid", 32'(lsuReqValid),  32'(live && mState == ST_MEM));
        checkOutput("lsu_req_wen",   32'(lsuReqWen),    32'(live && mState == ST_MEM && mStore));
        checkOutput("pc_wen",        32'(pcWen),        32'(live && mState == ST_WB));
        checkOutput("rf_wen",        32'(rfWen),        32'(live && mState == ST_WB && mRfw && !mStore));
        checkOutput("halted",        32'(halted),       32'(mHalted));
        checkOutput("fault",         32'(fault),        32'(mFault));
        checkOutput("fault_cause",   32'(faultCause),   32'(mCause));
        checkOutput("cycle_cnt",     32'(cycleCnt),     32'(mCycle));
        checkOutput("instret",       32'(instret),      32'(mInstret));
    endtask

    // Advance the model across one clock edge using the applied inputs.
    task automatic modelAdvance();
        bit          handshake;
        bit          expire;
        bit          fetchSide;
        ctrl_state_e nextState;
        if (!rst) begin
            mState     = ST_IDLE;
            mWaited    = 0;
            mStore     = 0;
            mRfw       = 0;
            mHalted    = 0;
            mFault     = 0;
            mCause     = 0;
            mCycle     = 0;
            mInstret   = 0;
            modelValid = 1;
        end else begin
            expire    = (mWaited + 1) >= TIMEOUT;
            fetchSide = (mState == ST_FETCH) || (mState == ST_WAIT_I);
            if (!(mState == ST_IDLE || mState == ST_HALT || mState == ST_FAULT))
                mCycle = (mCycle + 1) % CNT_MOD;
            case (mState)
                ST_IDLE: begin
                    if (start) begin
                        mState  = ST_FETCH;
                        mWaited = 0;
                    end
                end
                ST_FETCH, ST_WAIT_I, ST_MEM, ST_WAIT_M: begin
                    case (mState)
                        ST_FETCH:  begin handshake = ifuReqReady;  nextState = ST_WAIT_I; end
                        ST_WAIT_I: begin handshake = ifuRespValid; nextState = ST_EXEC;   end
                        ST_MEM:    begin handshake = lsuReqReady;  nextState = ST_WAIT_M; end
                        default:   begin handshake = lsuRespValid; nextState = ST_WB;     end
                    endcase
                    if (handshake) begin
                        mState = nextState;
                        mWaited++;
                    end else if (expire) begin
                        mState = ST_FAULT;
                        mFault = 1;
                        mCause = fetchSide ? 1 : 2;
                    end else begin
                        mWaited++;
                    end
                end
                ST_EXEC: begin
                    mStore = isStore;
                    mRfw   = rfWrite;
                    if (isEbreak) begin
                        mState   = ST_HALT;
                        mHalted  = 1;
                        mInstret = (mInstret + 1) % CNT_MOD;
                    end else if (isLoad || isStore) begin
                        mState  = ST_MEM;
                        mWaited = 0;
                    end else begin
                        mState = ST_WB;
                    end
                end
                ST_WB: begin
                    mInstret = (mInstret + 1) % CNT_MOD;
                    mState   = ST_FETCH;
                    mWaited  = 0;
                end
                default: begin
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), check the DUT
    // against the model mid-cycle, then step across the rising edge and
    // return at the next falling edge.
    task automatic applyStimulus(input bit r, input bit s, input bit fRdy, input bit fRsp,
                                 input bit ld, input bit st, input bit rw, input bit eb,
                                 input bit lRdy, input bit lRsp);
        rst          = r;
        start        = s;
        ifuReqReady  = fRdy;
        ifuRespValid = fRsp;
        isLoad       = ld;
        isStore      = st;
        rfWrite      = rw;
        isEbreak     = eb;
        lsuReqReady  = lRdy;
        lsuRespValid = lRsp;
        #1;
        if (modelValid) checkAgainstModel();
        pcSeen     += int'(pcWen === 1'b1);
        rfSeen     += int'(rfWen === 1'b1);
        wenSeen    += int'(lsuReqWen === 1'b1);
        lsuReqSeen += int'(lsuReqValid === 1'b1);
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearSeen();
        pcSeen     = 0;
        rfSeen     = 0;
        wenSeen    = 0;
        lsuReqSeen = 0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ifuReqReady = 1'b0; ifuRespValid = 1'b0;
        isLoad = 1'b0; isStore = 1'b0; rfWrite = 1'b0; isEbreak = 1'b0;
        lsuReqReady = 1'b0; lsuRespValid = 1'b0;
        clearSeen();
        @(negedge clk);

        // Reset
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        checkOutput("reset_state",   32'(state),      32'(ST_IDLE));
        checkOutput("reset_cycle",   32'(cycleCnt),   32'd0);
        checkOutput("reset_instret", 32'(instret),    32'd0);
        checkOutput("reset_flags",   32'({halted, fault, faultCause}), 32'd0);

        // ALU op with zero-wait fetch: FETCH, WAIT_I, EXEC, WB
        $display("[TB] ALU op, zero wait");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        clearSeen();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_state",   32'(state),    32'(ST_FETCH));
        checkOutput("alu_cycle",   32'(cycleCnt), 32'd4);
        checkOutput("alu_instret", 32'(instret),  32'd1);
        checkOutput("alu_pc_wen",  32'(pcSeen),   32'd1);
        checkOutput("alu_rf_wen",  32'(rfSeen),   32'd1);

        // Store, lsu_req_ready delayed 3 cycles; ready lands on the expiry cycle
        $display("[TB] store with delayed lsu ready");
        clearSeen();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("expire_race_state", 32'(state), 32'(ST_WAIT_M));
        checkOutput("expire_race_fault", 32'(fault), 32'd0);
        checkOutput("store_wen_cycles",  32'(wenSeen), 32'd4);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("store_pc_wen", 32'(pcSeen), 32'd1);
        checkOutput("store_rf_wen", 32'(rfSeen), 32'd0);
        checkOutput("store_cycle",  32'(cycleCnt), 32'd13);

        // Load with rf_write, zero-wait memory: six cycles
        $display("[TB] load zero wait");
        clearSeen();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("load_state",   32'(state),    32'(ST_FETCH));
        checkOutput("load_cycle",   32'(cycleCnt), 32'd19);
        checkOutput("load_rf_wen",  32'(rfSeen),   32'd1);
        checkOutput("load_instret", 32'(instret),  32'd3);

        // Fetch timeout: ifu_req_ready held low for TIMEOUT cycles
        $display("[TB] fetch timeout");
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fetch_to_state", 32'(state),      32'(ST_FAULT));
        checkOutput("fetch_to_cause", 32'(faultCause), 32'd1);
        checkOutput("fetch_to_fault", 32'(fault),      32'd1);
        for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        checkOutput("fault_sticky", 32'(state),    32'(ST_FAULT));
        checkOutput("fault_cycle",  32'(cycleCnt), 32'd23);

        // ebreak together with is_load: HALT, no memory request
        $display("[TB] ebreak with load");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        clearSeen();
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        checkOutput("halt_state",   32'(state),      32'(ST_HALT));
        checkOutput("halt_flag",    32'(halted),     32'd1);
        checkOutput("halt_instret", 32'(instret),    32'd1);
        checkOutput("halt_no_lsu",  32'(lsuReqSeen), 32'd0);
        checkOutput("halt_no_pc",   32'(pcSeen),     32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_rst_state",   32'(state),    32'(ST_IDLE));
        checkOutput("halt_rst_cycle",   32'(cycleCnt), 32'd0);
        checkOutput("halt_rst_instret", 32'(instret),  32'd0);
        checkOutput("halt_rst_flag",    32'(halted),   32'd0);

        // Random traffic, frequent resets and stalls
        $display("[TB] random phase A");
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(99) >= 4, $urandom_range(99) < 50,
                          $urandom_range(99) < 60, $urandom_range(99) < 60,
                          $urandom_range(99) < 25, $urandom_range(99) < 25,
                          $urandom_range(99) < 50, $urandom_range(99) < 3,
                          $urandom_range(99) < 60, $urandom_range(99) < 60);

        // Random traffic, long uninterrupted runs so the counters wrap
        $display("[TB] random phase B");
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(999) >= 2, $urandom_range(99) < 50,
                          $urandom_range(99) < 85, $urandom_range(99) < 85,
                          $urandom_range(99) < 25, $urandom_range(99) < 25,
                          $urandom_range(99) < 50, $urandom_range(999) < 5,
                          $urandom_range(99) < 85, $urandom_range(99) < 85);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
